// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state type, decimal constants and digit-count helper
package div_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam int DEC_BASE = 10;
  localparam int BCD_W    = 4;

  // Decimal digits needed to print the largest unsigned len-bit value.
  function automatic int ndig_for_len(input int len);
    longint unsigned v;
    int              n;
    v = (len >= 64) ? {64{1'b1}} : ((64'd1 << len) - 64'd1);
    n = 1;
    while (v >= 64'(DEC_BASE)) begin
      v = v / 64'(DEC_BASE);
      n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/dec_digits_seq.sv
// rtl/dec_digits_seq.sv - binary-to-BCD converter driving an external divide-by-10 unit
// Peels one decimal digit per divider pass, LSD first, until the quotient reaches zero.
module dec_digits_seq
  import div_pkg::*;
#(
  parameter int LEN  = 16,
  parameter int NDIG = 5
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      START,
  input  logic [LEN-1:0]            VALUE,
  output logic                      DONE,
  output logic [BCD_W*NDIG-1:0]     DIGITS,
  output logic [$clog2(NDIG+1)-1:0] COUNT,
  output logic                      ERR,
  output logic                      DIV_START,
  output logic [LEN-1:0]            DIV_A,
  output logic [LEN-1:0]            DIV_B,
  input  logic                      DIV_DONE,
  input  logic [LEN-1:0]            DIV_Q,
  input  logic [LEN-1:0]            DIV_R
);

  localparam int             CW        = $clog2(NDIG + 1);
  localparam logic [LEN-1:0] MAX_DIGIT = LEN'(DEC_BASE - 1);
  localparam logic [CW-1:0]  COUNT_MAX = CW'(NDIG);

  if (LEN < BCD_W || NDIG < ndig_for_len(LEN)) begin : g_bad_params
    $error("dec_digits_seq: LEN must be >= 4 and NDIG must hold every LEN-bit value");
  end

  state_t           state_q, state_d;
  logic             first_q, first_d;
  logic [LEN-1:0]   div_a_q, div_a_d;
  logic [BCD_W-1:0] digits_q [NDIG];
  logic [BCD_W-1:0] digits_d [NDIG];
  logic [CW-1:0]    count_q, count_d, count_inc;
  logic             err_q, err_d;

  assign count_inc = (count_q == COUNT_MAX) ? count_q : count_q + CW'(1);

  always_comb begin
    state_d   = state_q;
    first_d   = 1'b0;
    div_a_d   = div_a_q;
    digits_d  = digits_q;
    count_d   = count_q;
    err_d     = err_q;
    DIV_START = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          div_a_d = VALUE;
          for (int i = 0; i < NDIG; i++) digits_d[i] = '0;
          count_d = '0;
          err_d   = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // A divider left running by a reset must drain before it is restarted.
        if (DIV_DONE) begin
          DIV_START = 1'b1;
          first_d   = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        // DIV_DONE from before the start strobe took effect is stale on the first cycle.
        if (!first_q && DIV_DONE) begin
          if (DIV_R > MAX_DIGIT) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            for (int i = 0; i < NDIG; i++) begin
              if (count_q == CW'(i)) digits_d[i] = DIV_R[BCD_W-1:0];
            end
            count_d = count_inc;
            if (DIV_Q == '0) begin
              state_d = IDLE;
            end else if (count_inc == COUNT_MAX) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end else begin
              div_a_d = DIV_Q;
              state_d = ISSUE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      first_q <= 1'b0;
      div_a_q <= '0;
      for (int i = 0; i < NDIG; i++) digits_q[i] <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      first_q  <= first_d;
      div_a_q  <= div_a_d;
      digits_q <= digits_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    DIGITS = '0;
    for (int i = 0; i < NDIG; i++) DIGITS[BCD_W*i +: BCD_W] = digits_q[i];
  end

  assign DONE  = (state_q == IDLE);
  assign COUNT = count_q;
  assign ERR   = err_q;
  assign DIV_A = div_a_q;
  assign DIV_B = LEN'(DEC_BASE);

endmodule

// File: tb/tb_dec_digits_seq.sv
// tb/tb_dec_digits_seq.sv - bench for dec_digits_seq with a behavioural LEN-cycle divider
module tb_dec_digits_seq;

  localparam int LEN  = 16;
  localparam int NDIG = 5;

  typedef struct {
    logic [19:0] digits;
    logic [2:0]  count;
    logic        err;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [LEN-1:0] value = '0;
  logic           done;
  logic [19:0]    digits;
  logic [2:0]     count;
  logic           err;
  logic           div_start;
  logic [LEN-1:0] div_a, div_b;
  logic           dv_done = 1'b1;
  logic [LEN-1:0] dv_q = '0, dv_r = '0;
  int             dv_cnt = 0;
  logic           force_bad_r = 1'b0;
  logic           force_q1 = 1'b0;

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  dec_digits_seq #(.LEN(LEN), .NDIG(NDIG)) dut (
    .CLK(clk), .RST(rst), .START(start), .VALUE(value),
    .DONE(done), .DIGITS(digits), .COUNT(count), .ERR(err),
    .DIV_START(div_start), .DIV_A(div_a), .DIV_B(div_b),
    .DIV_DONE(dv_done), .DIV_Q(dv_q), .DIV_R(dv_r)
  );

  always #5 clk = ~clk;

  // Divider: no reset, DONE low for exactly LEN cycles after a sampled start.
  always @(posedge clk) begin
    if (div_start) begin
      dv_done <= 1'b0;
      dv_cnt  <= LEN;
      if (div_b == '0) begin
        dv_q <= '1;
        dv_r <= div_a;
      end else begin
        dv_q <= force_q1 ? LEN'(1) : div_a / div_b;
        dv_r <= force_bad_r ? LEN'(12) : div_a % div_b;
      end
    end else if (!dv_done) begin
      dv_cnt <= dv_cnt - 1;
      if (dv_cnt == 1) dv_done <= 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t exp_conv(input logic [LEN-1:0] v);
    exp_t e;
    int   x;
    x = int'(v);
    e.digits = '0;
    for (int i = 0; i < NDIG; i++) begin
      e.digits[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    e.count = 3'd1;
    x = int'(v) / 10;
    while (x != 0) begin
      e.count = e.count + 3'd1;
      x = x / 10;
    end
    e.err = 1'b0;
    return e;
  endfunction

  // Scoreboard and strobe monitors, all sampled away from the active edge.
  logic rst_edge = 1'b0;
  logic done_prev = 1'b1;
  logic ds_prev = 1'b0;
  int   ds_cnt = 0;
  int   ds_bad = 0;

  always @(posedge clk) rst_edge <= rst;

  always @(negedge clk) begin
    if (rst_edge) begin
      sb.delete();
    end else if (done && !done_prev) begin
      if (sb.size() == 0) begin
        check_eq("sb_empty", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("sb_digits", 32'(digits), 32'(e.digits));
        check_eq("sb_count", 32'(count), 32'(e.count));
        check_eq("sb_err", 32'(err), 32'(e.err));
      end
    end
    done_prev <= done;
  end

  always @(negedge clk) begin
    if (div_start) ds_cnt <= ds_cnt + 1;
    if (div_start && (!dv_done || ds_prev)) ds_bad <= ds_bad + 1;
    ds_prev <= div_start;
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic start_conv(input logic [LEN-1:0] v, input exp_t e);
    if (done) sb.push_back(e);
    start = 1'b1;
    value = v;
    @(negedge clk);
    start = 1'b0;
  endtask

  // cyc counts posedges from the accepting edge through the one that raises DONE.
  task automatic wait_done(input int inj_cyc, input logic [LEN-1:0] inj_val, output int cyc);
    cyc = 1;
    while (!done && cyc < 400) begin
      if (cyc == inj_cyc) begin
        start = 1'b1;
        value = inj_val;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
  endtask

  initial begin
    int   cyc, ds0, bad0;
    exp_t e;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_done", 32'(done), 32'd1);
    check_eq("rst_digits", 32'(digits), 32'd0);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_div_start", 32'(div_start), 32'd0);
    check_eq("rst_div_a", 32'(div_a), 32'd0);
    check_eq("div_b", 32'(div_b), 32'd10);
    @(negedge clk);

    // VALUE=0: single pass
    start_conv(16'd0, exp_conv(16'd0));
    wait_done(0, '0, cyc);
    check_eq("lat_zero", 32'(cyc), 32'd19);
    @(negedge clk);

    // 65535 with an ignored START of 999 ten cycles in
    ds0 = ds_cnt; bad0 = ds_bad;
    e.digits = 20'h65535; e.count = 3'd5; e.err = 1'b0;
    start_conv(16'd65535, e);
    wait_done(10, 16'd999, cyc);
    check_eq("lat_max", 32'(cyc), 32'd91);
    @(negedge clk);
    check_eq("pulses_max", 32'(ds_cnt - ds0), 32'd5);
    check_eq("ds_bad_max", 32'(ds_bad - bad0), 32'd0);
    check_eq("still_idle", 32'(done), 32'd1);

    // 1234: four single-cycle strobes
    ds0 = ds_cnt; bad0 = ds_bad;
    e.digits = 20'h01234; e.count = 3'd4; e.err = 1'b0;
    start_conv(16'd1234, e);
    check_eq("div_a_latched", 32'(div_a), 32'd1234);
    wait_done(0, '0, cyc);
    check_eq("lat_1234", 32'(cyc), 32'd73);
    @(negedge clk);
    check_eq("pulses_1234", 32'(ds_cnt - ds0), 32'd4);
    check_eq("ds_bad_1234", 32'(ds_bad - bad0), 32'd0);

    // Reset mid-conversion while the divider is busy, then convert 42
    bad0 = ds_bad;
    start_conv(16'd65535, exp_conv(16'd65535));
    repeat (29) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_rst_done", 32'(done), 32'd1);
    check_eq("mid_rst_count", 32'(count), 32'd0);
    check_eq("mid_rst_digits", 32'(digits), 32'd0);
    check_eq("mid_rst_div_a", 32'(div_a), 32'd0);
    check_eq("mid_rst_div_busy", 32'(dv_done), 32'd0);
    @(negedge clk);
    e.digits = 20'h00042; e.count = 3'd2; e.err = 1'b0;
    start_conv(16'd42, e);
    wait_done(0, '0, cyc);
    check_eq("lat_after_rst", 32'(cyc), 32'd40);
    @(negedge clk);
    check_eq("ds_bad_rst", 32'(ds_bad - bad0), 32'd0);

    // Out-of-range remainder aborts on the first pass
    force_bad_r = 1'b1;
    e.digits = 20'h0; e.count = 3'd0; e.err = 1'b1;
    start_conv(16'd500, e);
    wait_done(0, '0, cyc);
    check_eq("lat_bad_r", 32'(cyc), 32'd19);
    check_eq("err_set", 32'(err), 32'd1);
    @(negedge clk);
    force_bad_r = 1'b0;
    start_conv(16'd5, exp_conv(16'd5));
    check_eq("err_cleared", 32'(err), 32'd0);
    wait_done(0, '0, cyc);
    check_eq("lat_five", 32'(cyc), 32'd19);
    @(negedge clk);

    // Quotient that never reaches zero fills every slot and flags overflow
    force_q1 = 1'b1;
    e.digits = 20'h11117; e.count = 3'd5; e.err = 1'b1;
    start_conv(16'd7, e);
    wait_done(0, '0, cyc);
    check_eq("lat_ovf", 32'(cyc), 32'd91);
    @(negedge clk);
    force_q1 = 1'b0;

    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
